ether_tx_pkg_buf: RTL

Ping-pong transmit packet buffer that sits directly upstream of the Ethernet MAC transmit path.
- Host/CSME side writes 16-bit frame words into one bank and commits it with a word length.
- The block raises the send interrupt to the MAC, supplies the committed length, and serves MAC word reads by address.
- It watches the MAC idle indication (renew_pkg) to detect frame completion, then frees the bank.

---
 rtl/ether_tx_pkg_buf.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ether_tx_pkg_buf.sv
// ---------------------------------------------------------------------------
// ether_tx_pkg_buf
//
// Ping-pong transmit packet buffer in front of the Ethernet MAC TX path.
// The host fills one bank with 16-bit frame words and commits it with a
// word length. The buffer then launches the frame to the MAC, which
// involves three steps. First, it raises o_send_irq for IRQ_HOLD cycles.
// Second, it presents the committed length on o_length. Third, it serves
// MAC word reads by address with one cycle of latency. Frame completion is
// detected from the MAC idle indication (i_renew_pkg: 1 -> 0 -> 1), after
// which the bank is handed back to the host.
//
// Optional build macro:
//   TXBUF_LEN_PAD_EN  When defined, o_length is raised to at least 30
//                     words. o_data also reads as zero at or beyond the
//                     committed length, so the MAC sees a zero-padded
//                     minimum-size frame.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_wr_en/addr/data   host word write into the current write bank
//   i_commit/_len       host commit of the current write bank with length
//   o_wr_free           current write bank is empty (host may write)
//   o_overflow          1-cycle pulse: commit attempted with no free bank
//   o_send_irq          send request level to the MAC
//   o_length            length (words) of the frame being sent
//   i_data_addr/o_data  MAC word read, registered (1-cycle latency)
//   i_renew_pkg         MAC idle indication (1 = idle)
//   o_sent              1-cycle pulse: frame done, bank released
//   o_timeout           1-cycle pulse: wait timed out, bank released anyway
//   o_busy              launch FSM not idle
// ---------------------------------------------------------------------------
module ether_tx_pkg_buf #(
    parameter int ADDR_W   = 10,
    parameter int IRQ_HOLD = 4,
    parameter int TIMEOUT  = 4095
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [15:0]       i_wr_data,
    input  logic              i_commit,
    input  logic [ADDR_W-1:0] i_commit_len,
    output logic              o_wr_free,
    output logic              o_overflow,
    output logic              o_send_irq,
    output logic [ADDR_W-1:0] o_length,
    input  logic [ADDR_W-1:0] i_data_addr,
    output logic [15:0]       o_data,
    input  logic              i_renew_pkg,
    output logic              o_sent,
    output logic              o_timeout,
    output logic              o_busy
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef TXBUF_LEN_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] MIN_LEN     = ADDR_W'(30);
    localparam logic [11:0]       IRQ_LAST    = 12'(IRQ_HOLD - 1);
    localparam logic [11:0]       TIMEOUT_CNT = 12'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IRQ,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RELEASE
    } state_t;

    state_t             state_reg, state_next;
    logic [11:0]        cnt_reg;
    logic               err_reg, err_next;
    logic               full_reg [0:1];
    logic [ADDR_W-1:0]  len_reg  [0:1];
    logic               wr_sel_reg;
    logic               rd_sel_reg;
    logic [ADDR_W-1:0]  length_reg;
    logic               send_irq_reg;
    logic               sent_reg;
    logic               timeout_reg;
    logic               overflow_reg;
    logic [15:0]        data_reg;

    logic               wr_free;
    logic               commit_ok;
    logic               release_now;
    logic               launch;
    logic               pad_zero;
    logic [ADDR_W-1:0]  launch_len;

    // Both banks live in one RAM; the bank select is the address MSB.
    logic [15:0] mem [0:2*DEPTH-1];

    assign wr_free     = ~full_reg[wr_sel_reg];
    assign commit_ok   = i_commit & wr_free;
    assign release_now = (state_reg == ST_RELEASE);
    assign launch      = (state_reg == ST_IDLE) & full_reg[rd_sel_reg] & i_renew_pkg;

    // Short-frame padding only applies to the bank being read by the MAC.
    assign pad_zero = PAD_EN && (i_data_addr >= len_reg[rd_sel_reg]);

    always_comb begin
        launch_len = len_reg[rd_sel_reg];
        if (PAD_EN && (launch_len < MIN_LEN)) begin
            launch_len = MIN_LEN;
        end
    end

    // ------------------------------------------------------------------
    // Storage: write port from the host, registered read port for the MAC
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_wr_en && wr_free) begin
            mem[{wr_sel_reg, i_wr_addr}] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_reg <= 16'h0000;
        end else if (pad_zero) begin
            data_reg <= 16'h0000;
        end else begin
            data_reg <= mem[{rd_sel_reg, i_data_addr}];
        end
    end

    // ------------------------------------------------------------------
    // Per-bank FULL flag and committed length. A commit and a release can
    // land in the same cycle; they always target different banks because
    // commit needs an empty bank and release only runs on a full one.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    full_reg[gi] <= 1'b0;
                    len_reg[gi]  <= '0;
                end else begin
                    if (commit_ok && (wr_sel_reg == 1'(gi))) begin
                        full_reg[gi] <= 1'b1;
                        len_reg[gi]  <= i_commit_len;
                    end else if (release_now && (rd_sel_reg == 1'(gi))) begin
                        full_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Launch FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (launch) begin
                    state_next = ST_IRQ;
                end
            end
            ST_IRQ: begin
                if (cnt_reg >= IRQ_LAST) begin
                    state_next = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (!i_renew_pkg) begin
                    state_next = ST_WAIT_DONE;
                end else if (cnt_reg >= TIMEOUT_CNT) begin
                    state_next = ST_RELEASE;
                    err_next   = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (i_renew_pkg) begin
                    state_next = ST_RELEASE;
                end else if (cnt_reg >= TIMEOUT_CNT) begin
                    state_next = ST_RELEASE;
                    err_next   = 1'b1;
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
                err_next   = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
                err_next   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Launch FSM: state, counter, bank pointers and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 12'd0;
            err_reg      <= 1'b0;
            wr_sel_reg   <= 1'b0;
            rd_sel_reg   <= 1'b0;
            length_reg   <= '0;
            send_irq_reg <= 1'b0;
            sent_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;

            // Time spent in the current state; saturates instead of wrapping.
            if (state_next != state_reg) begin
                cnt_reg <= 12'd0;
            end else if (cnt_reg != 12'hFFF) begin
                cnt_reg <= cnt_reg + 12'd1;
            end

            if (commit_ok) begin
                wr_sel_reg <= ~wr_sel_reg;
            end
            if (release_now) begin
                rd_sel_reg <= ~rd_sel_reg;
            end

            // Length is captured once per launch and held until the next.
            if (launch) begin
                length_reg <= launch_len;
            end

            // Registered from the next state so the request is a single
            // clean level for exactly the cycles spent in IRQ.
            send_irq_reg <= (state_next == ST_IRQ);

            sent_reg     <= release_now & ~err_reg;
            timeout_reg  <= release_now &  err_reg;
            overflow_reg <= i_commit & ~wr_free;
        end
    end

    assign o_wr_free  = wr_free;
    assign o_overflow = overflow_reg;
    assign o_send_irq = send_irq_reg;
    assign o_length   = length_reg;
    assign o_data     = data_reg;
    assign o_sent     = sent_reg;
    assign o_timeout  = timeout_reg;
    assign o_busy     = (state_reg != ST_IDLE);

endmodule
